// File: rtl/pll_reset_sequencer.sv
// Reset manager for a PLL: synchronises LOCK, waits for a stable hold-off,
// releases reset channels in ascending order and re-asserts them on lock loss.
module pll_reset_sequencer #(
  parameter int NUM_OUT      = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_CYCLES = 4,
  parameter int LOSS_FILTER  = 3,
  parameter int CNT_W        = 8
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               lock,
  input  logic               sw_reset,
  output logic [NUM_OUT-1:0] rst,
  output logic               ready,
  output logic [CNT_W-1:0]   loss_count,
  output logic [1:0]         dbg_state
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int STAGE_W = $clog2(STAGE_CYCLES) + 1;
  localparam int LOSS_W  = $clog2(LOSS_FILTER) + 1;
  localparam int IDX_W   = $clog2(NUM_OUT) + 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_CYCLES - 1);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_HOLD      = 2'd1,
    S_STAGE     = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Handshake: none; lock is a level sampled every edge, sw_reset is a
  // single-cycle request sampled on the edge it is high.

  state_t               r_state, w_state_nxt;
  logic                 r_sync1, r_sync2;
  logic                 w_lock_s;
  logic [HOLD_W-1:0]    r_hold_cnt, w_hold_nxt;
  logic [STAGE_W-1:0]   r_stage_cnt, w_stage_nxt;
  logic [LOSS_W-1:0]    r_loss_cnt, w_loss_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [NUM_OUT-1:0]   r_rst, w_rst_nxt;
  logic                 r_ready, w_ready_nxt;
  logic [CNT_W-1:0]     r_loss_count, w_loss_count_nxt;
  logic [NUM_OUT-1:0]   w_released;

  // Channels 0..up_to are released (low); everything above stays in reset.
  function automatic logic [NUM_OUT-1:0] f_release(input logic [IDX_W-1:0] up_to);
    logic [NUM_OUT-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_OUT; i++) begin
      v[i] = (IDX_W'(i) > up_to);
    end
    return v;
  endfunction

  assign w_lock_s = r_sync2;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= lock;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state      <= S_WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_stage_cnt  <= '0;
      r_loss_cnt   <= '0;
      r_idx        <= '0;
      r_rst        <= '1;
      r_ready      <= 1'b0;
      r_loss_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_stage_cnt  <= w_stage_nxt;
      r_loss_cnt   <= w_loss_nxt;
      r_idx        <= w_idx_nxt;
      r_rst        <= w_rst_nxt;
      r_ready      <= w_ready_nxt;
      r_loss_count <= w_loss_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold_cnt;
    w_stage_nxt      = r_stage_cnt;
    w_loss_nxt       = r_loss_cnt;
    w_idx_nxt        = r_idx;
    w_rst_nxt        = r_rst;
    w_ready_nxt      = r_ready;
    w_loss_count_nxt = r_loss_count;

    unique case (r_state)
      // WAIT_LOCK keeps hold_cnt at zero, so the first high sample there is
      // handled exactly like a hold sample; only sw_reset treatment differs.
      S_WAIT_LOCK, S_HOLD: begin
        w_stage_nxt = '0;
        w_idx_nxt   = '0;
        w_loss_nxt  = '0;
        w_rst_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_hold_nxt  = '0;
        end else if (r_state == S_HOLD && sw_reset) begin
          w_hold_nxt  = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_hold_nxt = '0;
          if (NUM_OUT == 1) begin
            w_state_nxt = S_RUN;
            w_rst_nxt   = '0;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = S_STAGE;
            w_idx_nxt   = IDX_ONE;
            w_rst_nxt   = f_release('0);
          end
        end else begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = r_hold_cnt + 1'b1;
        end
      end

      S_STAGE, S_RUN: begin
        if (!w_lock_s && r_loss_cnt == LOSS_LAST) begin
          // Loss wins over a coincident sw_reset.
          w_state_nxt = S_WAIT_LOCK;
          w_hold_nxt  = '0;
          w_stage_nxt = '0;
          w_loss_nxt  = '0;
          w_idx_nxt   = '0;
          w_rst_nxt   = '1;
          w_ready_nxt = 1'b0;
          if (r_loss_count != '1) begin
            w_loss_count_nxt = r_loss_count + 1'b1;
          end
        end else if (sw_reset) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = '0;
          w_stage_nxt = '0;
          w_loss_nxt  = '0;
          w_idx_nxt   = '0;
          w_rst_nxt   = '1;
          w_ready_nxt = 1'b0;
        end else begin
          w_loss_nxt = w_lock_s ? '0 : r_loss_cnt + 1'b1;
          if (r_state == S_STAGE) begin
            if (r_stage_cnt == STAGE_LAST) begin
              w_stage_nxt = '0;
              w_rst_nxt   = f_release(r_idx);
              if (r_idx == IDX_LAST) begin
                w_state_nxt = S_RUN;
                w_ready_nxt = 1'b1;
                w_idx_nxt   = '0;
              end else begin
                w_idx_nxt = r_idx + 1'b1;
              end
            end else begin
              w_stage_nxt = r_stage_cnt + 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_nxt = S_WAIT_LOCK;
      end
    endcase
  end

  assign rst        = r_rst;
  assign ready      = r_ready;
  assign loss_count = r_loss_count;
  assign dbg_state  = r_state;

  // Released channels always form a contiguous run starting at channel 0.
  assign w_released = ~r_rst;

  assert property (@(posedge clock) disable iff (!rst_n) r_ready |-> (r_rst == '0));
  assert property (@(posedge clock) disable iff (!rst_n)
                   ((w_released & (w_released + 1'b1)) == '0));

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a 3-channel and a 1-channel build share one
// stimulus stream and are checked cycle by cycle against a sample-count model.
module tb_pll_reset_sequencer;

  localparam int H    = 16;
  localparam int S    = 4;
  localparam int L    = 3;
  localparam int CW   = 8;
  localparam int NO0  = 3;
  localparam int NO1  = 1;
  localparam int W0   = NO0 + 1 + CW;
  localparam int W1   = NO1 + 1 + CW;
  localparam int SAT  = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic lock;
  logic sw_reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NO0-1:0] rst0;
  logic           ready0;
  logic [CW-1:0]  loss0;
  logic [1:0]     dbg0;
  logic [NO1-1:0] rst1;
  logic           ready1;
  logic [CW-1:0]  loss1;
  logic [1:0]     dbg1;

  pll_reset_sequencer #(
    .NUM_OUT(NO0), .HOLD_CYCLES(H), .STAGE_CYCLES(S), .LOSS_FILTER(L), .CNT_W(CW)
  ) dut0 (
    .clock(clk), .rst_n(rst_n), .lock(lock), .sw_reset(sw_reset),
    .rst(rst0), .ready(ready0), .loss_count(loss0), .dbg_state(dbg0)
  );

  pll_reset_sequencer #(
    .NUM_OUT(NO1), .HOLD_CYCLES(H), .STAGE_CYCLES(S), .LOSS_FILTER(L), .CNT_W(CW)
  ) dut1 (
    .clock(clk), .rst_n(rst_n), .lock(lock), .sw_reset(sw_reset),
    .rst(rst1), .ready(ready1), .loss_count(loss1), .dbg_state(dbg1)
  );

  // ---------------- reference model ----------------
  // n counts samples since the current hold began; once n >= H the number of
  // released channels follows directly as 1 + (n-H)/S, capped at the channel count.
  bit m_s1   [2];
  bit m_s2   [2];
  bit m_wait [2];
  int m_n    [2];
  int m_low  [2];
  int m_loss [2];

  function automatic int num_out_of(input int d);
    return (d == 0) ? NO0 : NO1;
  endfunction

  function automatic int released(input int d);
    int k;
    if (m_n[d] < H) return 0;
    k = 1 + (m_n[d] - H) / S;
    return (k > num_out_of(d)) ? num_out_of(d) : k;
  endfunction

  task automatic model_step(input int d, input bit rn, input bit lk, input bit sw);
    bit ls;
    int cap;
    cap = H + num_out_of(d) * S;
    if (!rn) begin
      m_s1[d] = 1'b0; m_s2[d] = 1'b0; m_wait[d] = 1'b1;
      m_n[d] = 0; m_low[d] = 0; m_loss[d] = 0;
    end else begin
      ls = m_s2[d];
      m_s2[d] = m_s1[d];
      m_s1[d] = lk;
      if (m_n[d] >= H) begin
        if (!ls && m_low[d] + 1 == L) begin
          m_wait[d] = 1'b1; m_n[d] = 0; m_low[d] = 0;
          if (m_loss[d] < SAT) m_loss[d]++;
        end else if (sw) begin
          m_wait[d] = 1'b0; m_n[d] = 0; m_low[d] = 0;
        end else begin
          m_low[d] = ls ? 0 : m_low[d] + 1;
          m_n[d]   = (m_n[d] + 1 > cap) ? cap : m_n[d] + 1;
        end
      end else begin
        if (!ls) begin
          m_wait[d] = 1'b1; m_n[d] = 0;
        end else if (sw && !m_wait[d]) begin
          m_n[d] = 0;
        end else begin
          m_wait[d] = 1'b0; m_n[d]++;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W0-1:0] exp_q0[$];
  logic [W1-1:0] exp_q1[$];
  int total;
  int bad;
  int cyc;

  task automatic push_expected();
    logic [NO0-1:0] r0;
    logic [NO1-1:0] r1;
    r0 = '1;
    r1 = '1;
    r0 = r0 << released(0);
    r1 = r1 << released(1);
    exp_q0.push_back({r0, (released(0) == NO0), CW'(m_loss[0])});
    exp_q1.push_back({r1, (released(1) == NO1), CW'(m_loss[1])});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rn, input bit lk, input bit sw);
    @(negedge clk);
    rst_n    = rn;
    lock     = lk;
    sw_reset = sw;
    model_step(0, rn, lk, sw);
    model_step(1, rn, lk, sw);
    push_expected();
  endtask

  task automatic drive_n(input int n, input bit lk);
    for (int i = 0; i < n; i++) drive(1'b1, lk, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [W0-1:0] e0;
    logic [W1-1:0] e1;
    #1;
    cyc++;
    if (exp_q0.size() > 0) begin
      e0 = exp_q0.pop_front();
      total++;
      if ({rst0, ready0, loss0} !== e0) begin
        bad++;
        $display("FAIL dut0 cycle %0d: got rst=%b ready=%b loss=%0d, expected rst=%b ready=%b loss=%0d",
                 cyc, rst0, ready0, loss0, e0[W0-1 -: NO0], e0[CW], e0[CW-1:0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      total++;
      if ({rst1, ready1, loss1} !== e1) begin
        bad++;
        $display("FAIL dut1 cycle %0d: got rst=%b ready=%b loss=%0d, expected rst=%b ready=%b loss=%0d",
                 cyc, rst1, ready1, loss1, e1[W1-1 -: NO1], e1[CW], e1[CW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    bit lk_cur;
    int run_left;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; lock = 1'b1; sw_reset = 1'b0;

    // Reset with lock already high, then a clean power-up sequence.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
    drive_n(40, 1'b1);

    // Loss, relock, then a single-sample glitch part way through the hold.
    drive_n(3, 1'b0);
    drive_n(11, 1'b1);
    drive_n(1, 1'b0);
    drive_n(40, 1'b1);

    // Short lows in RUN are filtered; a third low sample is a loss.
    drive_n(2, 1'b0);
    drive_n(10, 1'b1);
    drive_n(3, 1'b0);
    drive_n(40, 1'b1);

    // Soft reset in RUN.
    drive(1'b1, 1'b1, 1'b1);
    drive_n(40, 1'b1);

    // Soft reset on the very edge the loss filter expires.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, (m_n[0] >= H && m_low[0] == L - 1 && m_s2[0] == 1'b0));
    end
    drive_n(40, 1'b1);

    // Soft reset during STAGE and during HOLD.
    drive_n(3, 1'b0);
    drive_n(22, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive_n(8, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive_n(40, 1'b1);

    // rst_n while only channel 0 is released.
    drive_n(3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      found = (released(0) == 1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stage_reach: got no partial release in 100 cycles, expected rst=110");
    end
    drive(1'b0, 1'b1, 1'b0);
    drive_n(40, 1'b1);

    // Saturate the loss counter.
    for (int i = 0; i < 260; i++) begin
      drive_n(17, 1'b1);
      drive_n(3, 1'b0);
    end
    drive_n(40, 1'b1);

    // Randomised bursts of lock, soft resets and occasional rst_n.
    lk_cur = 1'b1;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        lk_cur   = ($urandom_range(0, 3) != 0);
        run_left = lk_cur ? $urandom_range(5, 40) : $urandom_range(1, 4);
      end
      run_left--;
      drive(($urandom_range(0, 299) != 0), lk_cur, ($urandom_range(0, 39) == 0));
    end
    drive_n(5, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
